audio_pwm_out: RTL and testbench
================================

// Module: audio_pwm_out
// PURPOSE
//  Stereo audio output stage driving pwm_l/pwm_r. Accepts 8-bit unsigned L/R sample pairs from the
//  SPI cart bridge over valid/ready, buffers them in a FIFO, releases them at a fixed sample rate
//  and renders each channel as 8-bit PWM at clk_8m/256 (31.25 kHz carrier). While enable=0 the
//  startup screen's pwm_out passes through to both pins.
// PARAMETERS
//  SAMPLE_DIV  500  clk_8m cycles per sample tick (16 kHz); legal range 256..65535
//  DEPTH       16   FIFO entries, power of two
// PORTS
//  clk_8m        in   1   system clock, 8 MHz
//  nrst          in   1   synchronous reset, active low
//  enable        in   1   1 = play FIFO samples; 0 = pass startup_pwm through
//  s_valid       in   1   sample pair valid
//  s_data        in   16  {L[15:8], R[7:0]}, unsigned, 0x80 = silence
//  s_ready       out  1   FIFO can accept; registered
//  startup_pwm   in   1   PWM from startup screen generator
//  pwm_l         out  1   left PWM, registered
//  pwm_r         out  1   right PWM, registered
//  fifo_level    out  5   entries held, 0..DEPTH
//  underrun_cnt  out  8   sample ticks with empty FIFO, saturating
// BEHAVIOUR
//  Reset (nrst=0 at clk edge): pwm_l/pwm_r=0, s_ready=0, fifo_level=0, underrun_cnt=0, FIFO
//   pointers=0, divider=0, pwm_cnt=0, staged_l/r=cur_l/r=0x80. s_ready rises on first edge with nrst=1.
//  Push: s_valid & s_ready at edge writes s_data. s_ready next = (level_next < DEPTH); never
//   asserted while full. Sender holds s_data until accepted.
//  Divider: counts 0..SAMPLE_DIV-1 only while enable=1; tick = 1 cycle when count==SAMPLE_DIV-1,
//   then wraps to 0. enable=0 clears divider to 0; first tick SAMPLE_DIV cycles after enable rises.
//  Pop: on tick with level>0, head -> staged_l/r. On tick with level==0: no pop, staged unchanged
//   (last sample held), underrun_cnt += 1 saturating at 255. Push and pop same cycle: level
//   unchanged. Push into empty FIFO on a tick cycle is not popped that tick (counts as underrun).
//  PWM: pwm_cnt 8-bit free-running, wraps 255->0. On edge where pwm_cnt==255, cur_l/r <= staged_l/r
//   (glitch-free update at period boundary). Two ticks in one period cannot occur (SAMPLE_DIV>=256).
//  Output (registered): enable=1: pwm_x <= (pwm_cnt < cur_x); duty = cur_x/256; 0x00 -> constant
//   low, 0xFF -> high 255 of 256 cycles. enable=0: pwm_l = pwm_r <= startup_pwm (1-cycle delay).
//  enable=0 also resets staged_l/r and cur_l/r to 0x80; FIFO contents and underrun_cnt retained;
//   pushes still accepted.
//  Latency: push into empty FIFO -> pop at next tick -> cur at next pwm_cnt==255 -> new duty visible
//   on pwm_x from the following cycle. Worst case SAMPLE_DIV+256+1 cycles.
//  fifo_level = write_ptr - read_ptr with extra wrap bit; ptrs are log2(DEPTH)+1 bits.
//  Reset mid-stream: FIFO flushed, all state as above at that edge; partially sent pair is lost.
// TESTING
//  1 Hold nrst=0 for 3 cycles -> pwm_l/r=0, s_ready=0, level=0, underrun_cnt=0; s_ready=1 one cycle after release.
//  2 enable=0, toggle startup_pwm 0,1,1,0 -> pwm_l and pwm_r equal it delayed by exactly 1 cycle.
//  3 SAMPLE_DIV=300, enable=1, push 0xC040 -> after tick and wrap, pwm_l high 192/256 and pwm_r high
//    64/256 per period; held for subsequent periods with empty FIFO.
//  4 enable=0, push 16 pairs back-to-back -> level=16, s_ready=0 after 16th accept; 17th held until
//    enable=1 and first tick pops one (level 15 -> s_ready=1 -> 17th accepted).
//  5 enable=1, FIFO empty for 3 ticks -> underrun_cnt=3, duty 128/256 both; 300 ticks -> saturates at 255.
//  6 Push 4 pairs, assert nrst mid-push -> next cycle level=0, s_ready=0, pwm_l/r=0; earlier samples never output.

Source files
------------

// File: rtl/audio_pwm_out_if.sv
// Sample stream interface between the SPI cart bridge and the audio PWM
// output stage. Each transfer carries one stereo pair {L[15:8], R[7:0]}.
interface audio_pwm_out_if;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );
endinterface

// File: rtl/audio_pwm_out.sv
// Stereo audio output stage: buffers 8-bit unsigned L/R pairs in a FIFO,
// releases one pair per sample tick, and renders each channel as 8-bit PWM
// at clk_8m/256. While enable is low the startup screen PWM is passed
// through to both pins and the playback registers return to silence.
module audio_pwm_out #(
  parameter int unsigned SAMPLE_DIV = 500,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                     clk_8m,
  input  logic                     nrst,
  input  logic                     enable,
  audio_pwm_out_if.slave           s,
  input  logic                     startup_pwm,
  output logic                     pwm_l,
  output logic                     pwm_r,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [7:0]               underrun_cnt
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned PW       = AW + 1;
  localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [7:0]  SILENCE  = 8'h80;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [15:0]   div_q, div_d;
  logic [7:0]    pwm_cnt_q, pwm_cnt_d;
  logic [7:0]    staged_l_q, staged_l_d;
  logic [7:0]    staged_r_q, staged_r_d;
  logic [7:0]    cur_l_q, cur_l_d;
  logic [7:0]    cur_r_q, cur_r_d;
  logic [7:0]    underrun_q, underrun_d;
  logic          s_ready_q, s_ready_d;
  logic          pwm_l_q, pwm_l_d;
  logic          pwm_r_q, pwm_r_d;
  logic [15:0]   mem_q [DEPTH];

  logic          push_s;
  logic          pop_s;
  logic          tick_s;
  logic [PW-1:0] level_s;
  logic [PW-1:0] level_next_s;
  logic [15:0]   head_s;

  // Next-state logic for FIFO, sample-rate divider, PWM carrier and outputs.
  always_comb begin
    push_s       = s.s_valid & s_ready_q;
    level_s      = wr_ptr_q - rd_ptr_q;
    tick_s       = enable & (div_q == DIV_LAST);
    // Level is taken before this cycle's push, so a pair written into an
    // empty FIFO on a tick cycle waits for the next tick.
    pop_s        = tick_s & (level_s != {PW{1'b0}});
    head_s       = mem_q[rd_ptr_q[AW-1:0]];

    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    div_d        = div_q;
    pwm_cnt_d    = pwm_cnt_q + 8'd1;
    staged_l_d   = staged_l_q;
    staged_r_d   = staged_r_q;
    cur_l_d      = cur_l_q;
    cur_r_d      = cur_r_q;
    underrun_d   = underrun_q;
    pwm_l_d      = 1'b0;
    pwm_r_d      = 1'b0;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    level_next_s = wr_ptr_d - rd_ptr_d;
    s_ready_d    = (level_next_s < DEPTH_P);

    if (!enable) begin
      div_d = 16'd0;
    end else if (tick_s) begin
      div_d = 16'd0;
    end else begin
      div_d = div_q + 16'd1;
    end

    if (tick_s && !pop_s && (underrun_q != 8'hFF)) begin
      underrun_d = underrun_q + 8'd1;
    end else begin
      underrun_d = underrun_q;
    end

    if (!enable) begin
      staged_l_d = SILENCE;
      staged_r_d = SILENCE;
    end else if (pop_s) begin
      staged_l_d = head_s[15:8];
      staged_r_d = head_s[7:0];
    end else begin
      staged_l_d = staged_l_q;
      staged_r_d = staged_r_q;
    end

    // Duty only changes at the carrier period boundary to avoid glitches.
    if (!enable) begin
      cur_l_d = SILENCE;
      cur_r_d = SILENCE;
    end else if (pwm_cnt_q == 8'hFF) begin
      cur_l_d = staged_l_q;
      cur_r_d = staged_r_q;
    end else begin
      cur_l_d = cur_l_q;
      cur_r_d = cur_r_q;
    end

    if (enable) begin
      pwm_l_d = (pwm_cnt_q < cur_l_q);
      pwm_r_d = (pwm_cnt_q < cur_r_q);
    end else begin
      pwm_l_d = startup_pwm;
      pwm_r_d = startup_pwm;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_8m) begin
    if (!nrst) begin
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      div_q      <= 16'd0;
      pwm_cnt_q  <= 8'd0;
      staged_l_q <= SILENCE;
      staged_r_q <= SILENCE;
      cur_l_q    <= SILENCE;
      cur_r_q    <= SILENCE;
      underrun_q <= 8'd0;
      s_ready_q  <= 1'b0;
      pwm_l_q    <= 1'b0;
      pwm_r_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      div_q      <= div_d;
      pwm_cnt_q  <= pwm_cnt_d;
      staged_l_q <= staged_l_d;
      staged_r_q <= staged_r_d;
      cur_l_q    <= cur_l_d;
      cur_r_q    <= cur_r_d;
      underrun_q <= underrun_d;
      s_ready_q  <= s_ready_d;
      pwm_l_q    <= pwm_l_d;
      pwm_r_q    <= pwm_r_d;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_8m) begin
    if (nrst && push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= s.s_data;
    end
  end

  assign s.s_ready    = s_ready_q;
  assign pwm_l        = pwm_l_q;
  assign pwm_r        = pwm_r_q;
  assign fifo_level   = wr_ptr_q - rd_ptr_q;
  assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_audio_pwm_out.sv
// Directed self-checking bench for audio_pwm_out. Instance a runs the main
// scenarios at SAMPLE_DIV=300; instance b runs at the minimum SAMPLE_DIV with
// an empty FIFO to reach underrun counter saturation.
module tb_audio_pwm_out;
  logic clk_8m = 1'b0;
  always #5 clk_8m = ~clk_8m;

  logic        nrst, nrst_b, enable, enable_b, startup_pwm;
  logic        pwm_l, pwm_r, pwm_l_b, pwm_r_b;
  logic [4:0]  fifo_level, fifo_level_b;
  logic [7:0]  underrun_cnt, underrun_cnt_b;
  int unsigned cyc = 0;
  int unsigned c0;
  int          vectors = 0;
  int          errs = 0;
  int          nl, nr;
  logic        prev_v, v;
  logic [3:0]  pat;

  audio_pwm_out_if bus_a ();
  audio_pwm_out_if bus_b ();

  audio_pwm_out #(.SAMPLE_DIV(300), .DEPTH(16)) dut_a (
    .clk_8m      (clk_8m),
    .nrst        (nrst),
    .enable      (enable),
    .s           (bus_a),
    .startup_pwm (startup_pwm),
    .pwm_l       (pwm_l),
    .pwm_r       (pwm_r),
    .fifo_level  (fifo_level),
    .underrun_cnt(underrun_cnt)
  );

  audio_pwm_out #(.SAMPLE_DIV(256), .DEPTH(16)) dut_b (
    .clk_8m      (clk_8m),
    .nrst        (nrst_b),
    .enable      (enable_b),
    .s           (bus_b),
    .startup_pwm (startup_pwm),
    .pwm_l       (pwm_l_b),
    .pwm_r       (pwm_r_b),
    .fifo_level  (fifo_level_b),
    .underrun_cnt(underrun_cnt_b)
  );

  always @(posedge clk_8m) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk_8m);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Count high cycles of each pin of instance a over one full carrier period.
  task automatic measure(output int cl, output int cr);
    cl = 0;
    cr = 0;
    repeat (256) begin
      step(1);
      cl += int'(pwm_l);
      cr += int'(pwm_r);
    end
  endtask

  initial begin
    nrst = 1'b0; nrst_b = 1'b0; enable = 1'b0; enable_b = 1'b1; startup_pwm = 1'b0;
    bus_a.s_valid = 1'b0; bus_a.s_data = 16'h0000;
    bus_b.s_valid = 1'b0; bus_b.s_data = 16'h0000;

    // 1: reset state
    step(3);
    check("rst_pwm_l", {15'd0, pwm_l}, 16'd0);
    check("rst_pwm_r", {15'd0, pwm_r}, 16'd0);
    check("rst_ready", {15'd0, bus_a.s_ready}, 16'd0);
    check("rst_level", {11'd0, fifo_level}, 16'd0);
    check("rst_underrun", {8'd0, underrun_cnt}, 16'd0);
    check("rst_underrun_b", {8'd0, underrun_cnt_b}, 16'd0);
    nrst = 1'b1; nrst_b = 1'b1;
    c0 = cyc;
    step(1);
    check("ready_after_rst", {15'd0, bus_a.s_ready}, 16'd1);

    // 2: startup_pwm passthrough with one cycle delay
    pat = 4'b0110;
    prev_v = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v = pat[3-i];
      startup_pwm = v;
      check("pass_pre", {15'd0, pwm_l}, {15'd0, prev_v});
      step(1);
      check("pass_l", {15'd0, pwm_l}, {15'd0, v});
      check("pass_r", {15'd0, pwm_r}, {15'd0, v});
      prev_v = v;
    end

    // 3: single pair 0xC040, then boundary pair 0xFF00
    bus_a.s_data = 16'hC040; bus_a.s_valid = 1'b1;
    step(1);
    bus_a.s_valid = 1'b0;
    check("t3_level1", {11'd0, fifo_level}, 16'd1);
    enable = 1'b1;
    step(299);
    check("t3_before_tick", {11'd0, fifo_level}, 16'd1);
    step(1);
    check("t3_after_tick", {11'd0, fifo_level}, 16'd0);
    step(260);
    measure(nl, nr);
    check("t3_duty_l", 16'(nl), 16'd192);
    check("t3_duty_r", 16'(nr), 16'd64);
    measure(nl, nr);
    check("t3_hold_l", 16'(nl), 16'd192);
    check("t3_hold_r", 16'(nr), 16'd64);
    bus_a.s_data = 16'hFF00; bus_a.s_valid = 1'b1;
    step(1);
    bus_a.s_valid = 1'b0;
    step(600);
    measure(nl, nr);
    check("t3_ff_l", 16'(nl), 16'd255);
    check("t3_00_r", 16'(nr), 16'd0);

    // 4: fill FIFO while disabled, 17th pair waits for the first pop
    nrst = 1'b0; enable = 1'b0;
    step(1);
    nrst = 1'b1;
    step(1);
    for (int i = 0; i < 16; i++) begin
      bus_a.s_data = (i < 2) ? 16'h20E0 : 16'(i * 16'h1111);
      bus_a.s_valid = 1'b1;
      step(1);
      if (i == 14) check("t4_ready_15", {15'd0, bus_a.s_ready}, 16'd1);
    end
    check("t4_full_level", {11'd0, fifo_level}, 16'd16);
    check("t4_full_ready", {15'd0, bus_a.s_ready}, 16'd0);
    bus_a.s_data = 16'hAAAA;
    step(5);
    check("t4_held_level", {11'd0, fifo_level}, 16'd16);
    enable = 1'b1;
    step(299);
    check("t4_pretick_level", {11'd0, fifo_level}, 16'd16);
    check("t4_pretick_ready", {15'd0, bus_a.s_ready}, 16'd0);
    step(1);
    check("t4_pop_level", {11'd0, fifo_level}, 16'd15);
    check("t4_pop_ready", {15'd0, bus_a.s_ready}, 16'd1);
    step(1);
    bus_a.s_valid = 1'b0;
    check("t4_17th_level", {11'd0, fifo_level}, 16'd16);
    check("t4_17th_ready", {15'd0, bus_a.s_ready}, 16'd0);
    step(259);
    measure(nl, nr);
    check("t4_first_l", 16'(nl), 16'd32);
    check("t4_first_r", 16'(nr), 16'd224);

    // 5: underruns on an empty FIFO
    nrst = 1'b0; enable = 1'b0;
    step(1);
    nrst = 1'b1; enable = 1'b1;
    step(899);
    check("t5_underrun2", {8'd0, underrun_cnt}, 16'd2);
    step(1);
    check("t5_underrun3", {8'd0, underrun_cnt}, 16'd3);
    measure(nl, nr);
    check("t5_silence_l", 16'(nl), 16'd128);
    check("t5_silence_r", 16'(nr), 16'd128);

    // 6: reset in the middle of a burst flushes everything
    bus_a.s_data = 16'hFFFF; bus_a.s_valid = 1'b1;
    step(3);
    check("t6_level3", {11'd0, fifo_level}, 16'd3);
    nrst = 1'b0;
    step(1);
    check("t6_rst_level", {11'd0, fifo_level}, 16'd0);
    check("t6_rst_ready", {15'd0, bus_a.s_ready}, 16'd0);
    check("t6_rst_pwm_l", {15'd0, pwm_l}, 16'd0);
    check("t6_rst_pwm_r", {15'd0, pwm_r}, 16'd0);
    nrst = 1'b1; bus_a.s_valid = 1'b0;
    step(560);
    check("t6_level_after", {11'd0, fifo_level}, 16'd0);
    measure(nl, nr);
    check("t6_silence_l", 16'(nl), 16'd128);
    check("t6_silence_r", 16'(nr), 16'd128);

    // 5b: saturation on instance b (tick every 256 cycles since release)
    while ((cyc - c0) < 32'd65279) step(1);
    check("sat_254", {8'd0, underrun_cnt_b}, 16'd254);
    step(1);
    check("sat_255", {8'd0, underrun_cnt_b}, 16'd255);
    step(1024);
    check("sat_hold", {8'd0, underrun_cnt_b}, 16'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
